// File: rtl/jump_sequencer.sv
// jump_sequencer: game-flow controller for the blocks datapath.
// Turns button edges into single-cycle jump pulses, blocks new jumps while
// the 5-layer shift animation runs, and generates each new row from an LFSR
// so that a safe column always lies within one step of the previous one.
// Optional build macro: JUMP_BUFFER_EN adds a one-entry jump request buffer
// that remembers the first single-direction edge seen during the animation.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no game running, blocks disabled, waiting for start edge
// READY | game running, next single-direction edge issues a jump
// SHIFT | animation running, anim_cnt counts down on one_ms_tick
// FAIL  | character fell, picture frozen, start edge returns to IDLE

module jump_sequencer #(
   parameter int          ANIM_MS    = 200,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          START_PATH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        one_ms_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_start,
   input  logic        jump_fail,
   output logic        module_en,
   output logic        jump_left,
   output logic        jump_right,
   output logic [0:6]  layer_map_out,
   output logic [0:6]  block_type_out,
   output logic [15:0] score,
   output logic        game_over
);

   typedef enum logic [1:0] {IDLE, READY, SHIFT, FAIL} state_t;

   localparam logic [9:0] ANIM_LOAD  = 10'(ANIM_MS);
   localparam logic [2:0] PATH_START = 3'(START_PATH);

   state_t      state;
   state_t      state_nxt;

   logic        prev_left;
   logic        prev_right;
   logic        prev_start;
   logic        left_edge;
   logic        right_edge;
   logic        start_edge;
   logic        single_edge;

   logic [9:0]  anim_cnt;
   logic [15:0] lfsr;
   logic [15:0] lfsr_adv;
   logic [2:0]  path;
   logic [2:0]  path_new;
   logic [0:6]  row_map;
   logic [0:6]  row_type;

   logic        issue;
   logic        issue_left;
   logic        module_en_d;
   logic        game_over_d;

   assign left_edge   = btn_left  & ~prev_left;
   assign right_edge  = btn_right & ~prev_right;
   assign start_edge  = btn_start & ~prev_start;
   assign single_edge = left_edge ^ right_edge;

`ifdef JUMP_BUFFER_EN
   logic buf_valid;
   logic buf_left;

   // Remember the first single-direction request made during the animation.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= 1'b0;
         buf_left  <= 1'b0;
      end else if (state != READY && state != SHIFT) begin
         buf_valid <= 1'b0;
      end else if (issue) begin
         buf_valid <= 1'b0;
      end else if (state == SHIFT && !jump_fail && !buf_valid && single_edge) begin
         buf_valid <= 1'b1;
         buf_left  <= left_edge;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a failing landing overrides any jump or expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_edge) state_nxt = READY;
         end
         READY: begin
            if (jump_fail)  state_nxt = FAIL;
            else if (issue) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (jump_fail)                              state_nxt = FAIL;
            else if (one_ms_tick && anim_cnt == 10'd1) state_nxt = READY;
         end
         FAIL: begin
            if (start_edge) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: jump decision plus next values of the level outputs.
   always_comb begin
      issue      = 1'b0;
      issue_left = 1'b0;
      if (state == READY && !jump_fail) begin
         if (single_edge) begin
            issue      = 1'b1;
            issue_left = left_edge;
         end
`ifdef JUMP_BUFFER_EN
         // A buffered request takes precedence over a live edge.
         if (buf_valid) begin
            issue      = 1'b1;
            issue_left = buf_left;
         end
`endif
      end
      module_en_d = (state_nxt != IDLE);
      game_over_d = (state_nxt == FAIL);
   end

   // Next row: advance LFSR, wander the safe path by at most one column.
   always_comb begin
      lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (lfsr_adv[1:0])
         2'd0:    path_new = (path == 3'd0) ? 3'd0 : path - 3'd1;
         2'd1:    path_new = (path >= 3'd6) ? 3'd6 : path + 3'd1;
         default: path_new = path;
      endcase
      row_map           = lfsr_adv[15:9];
      row_map[path_new] = 1'b1;
      row_type           = lfsr_adv[8:2] & row_map;
      row_type[path_new] = 1'b0;
   end

   // Registered datapath: edge detect, jump pulses, rows, score, timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_left      <= 1'b0;
         prev_right     <= 1'b0;
         prev_start     <= 1'b0;
         module_en      <= 1'b0;
         jump_left      <= 1'b0;
         jump_right     <= 1'b0;
         layer_map_out  <= '0;
         block_type_out <= '0;
         score          <= 16'd0;
         game_over      <= 1'b0;
         lfsr           <= LFSR_SEED;
         path           <= PATH_START;
         anim_cnt       <= 10'd0;
      end else begin
         prev_left  <= btn_left;
         prev_right <= btn_right;
         prev_start <= btn_start;
         module_en  <= module_en_d;
         game_over  <= game_over_d;
         jump_left  <= 1'b0;
         jump_right <= 1'b0;

         if (issue) begin
            jump_left      <= issue_left;
            jump_right     <= ~issue_left;
            lfsr           <= lfsr_adv;
            path           <= path_new;
            layer_map_out  <= row_map;
            block_type_out <= row_type;
            anim_cnt       <= ANIM_LOAD;
            if (score != 16'hFFFF) score <= score + 16'd1;
         end else if (state == SHIFT && one_ms_tick && anim_cnt != 10'd0) begin
            anim_cnt <= anim_cnt - 10'd1;
         end

         if (state == IDLE && start_edge) begin
            score <= 16'd0;
            path  <= PATH_START;
         end

         // Returning to IDLE also wipes the last row so blocks restarts clean.
         if (state == FAIL && start_edge) begin
            layer_map_out  <= '0;
            block_type_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed bench for jump_sequencer (default parameters).
// Build with JUMP_BUFFER_EN defined to exercise the request buffer.

module tb_jump_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        one_ms_tick = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_start = 1'b0;
   logic        jump_fail = 1'b0;
   logic        module_en;
   logic        jump_left;
   logic        jump_right;
   logic [0:6]  layer_map_out;
   logic [0:6]  block_type_out;
   logic [15:0] score;
   logic        game_over;

   int total = 0;
   int bad   = 0;

`ifdef JUMP_BUFFER_EN
   localparam logic BUF_EN = 1'b1;
`else
   localparam logic BUF_EN = 1'b0;
`endif

   // Reference model of the row generator.
   logic [15:0] m_lfsr;
   int          m_path;
   logic [0:6]  m_map;
   logic [0:6]  m_type;

   jump_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .one_ms_tick    (one_ms_tick),
      .btn_left       (btn_left),
      .btn_right      (btn_right),
      .btn_start      (btn_start),
      .jump_fail      (jump_fail),
      .module_en      (module_en),
      .jump_left      (jump_left),
      .jump_right     (jump_right),
      .layer_map_out  (layer_map_out),
      .block_type_out (block_type_out),
      .score          (score),
      .game_over      (game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         one_ms_tick = 1'b1;
         step();
         one_ms_tick = 1'b0;
         step();
      end
   endtask

   task automatic model_jump();
      logic fb;
      int   r;
      fb     = ^(m_lfsr & 16'hB400);
      m_lfsr = {m_lfsr[14:0], fb};
      r      = int'(m_lfsr[1:0]);
      if (r == 0)      m_path = (m_path > 0) ? m_path - 1 : 0;
      else if (r == 1) m_path = (m_path < 6) ? m_path + 1 : 6;
      m_map          = m_lfsr[15:9];
      m_map[m_path]  = 1'b1;
      m_type         = m_lfsr[8:2] & m_map;
      m_type[m_path] = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_module_en"},  32'(module_en), 32'd0);
      chk({tag, "_jump_left"},  32'(jump_left), 32'd0);
      chk({tag, "_jump_right"}, 32'(jump_right), 32'd0);
      chk({tag, "_layer_map"},  32'(layer_map_out), 32'd0);
      chk({tag, "_block_type"}, 32'(block_type_out), 32'd0);
      chk({tag, "_score"},      32'(score), 32'd0);
      chk({tag, "_game_over"},  32'(game_over), 32'd0);
   endtask

   initial begin
      int cnt;
      int prev;
      int safe;

      m_lfsr = 16'hACE1;
      m_path = 3;

      // Reset state
      step();
      step();
      chk_reset("reset");
      rst = 1'b0;
      step();

      // Start edge
      btn_start = 1'b1;
      step();
      chk("start_module_en", 32'(module_en), 32'd1);
      chk("start_score", 32'(score), 32'd0);
      chk("start_layer_map", 32'(layer_map_out), 32'd0);
      chk("start_no_pulse", 32'({jump_left, jump_right}), 32'd0);
      btn_start = 1'b0;

      // First jump: right edge; LFSR ACE1 -> 59C3, path stays 3
      btn_right = 1'b1;
      step();
      model_jump();
      chk("j1_jump_right", 32'(jump_right), 32'd1);
      chk("j1_jump_left", 32'(jump_left), 32'd0);
      chk("j1_score", 32'(score), 32'd1);
      chk("j1_layer_map", 32'(layer_map_out), 32'(7'b0101100));
      chk("j1_block_type", 32'(block_type_out), 32'(7'b0100000));
      chk("j1_safe_map", 32'(layer_map_out[m_path]), 32'd1);
      chk("j1_safe_type", 32'(block_type_out[m_path]), 32'd0);
      step();
      chk("j1_pulse_one_cycle", 32'(jump_right), 32'd0);
      btn_right = 1'b0;

      // Edges during animation do not produce pulses
      ticks(5);
      btn_left = 1'b1;
      step();
      chk("shift_edge_ignored", 32'(jump_left), 32'd0);
      btn_left = 1'b0;
      step();
      chk("shift_edge_ignored2", 32'(jump_left), 32'd0);
      ticks(194);
      btn_left = 1'b1;
      step();
      chk("edge_at_cnt1_ignored", 32'(jump_left), 32'd0);
      btn_left = 1'b0;
      step();

      // 200th tick returns to READY; left edge then jumps (59C3 -> B387)
      one_ms_tick = 1'b1;
      step();
      one_ms_tick = 1'b0;
      btn_left = 1'b1;
      step();
      model_jump();
      chk("j2_jump_left", 32'(jump_left), 32'd1);
      chk("j2_score", 32'(score), 32'd2);
      chk("j2_layer_map", 32'(layer_map_out), 32'(7'b1011001));
      chk("j2_block_type", 32'(block_type_out), 32'(7'b1000001));
      btn_left = 1'b0;
      step();
      chk("j2_pulse_one_cycle", 32'(jump_left), 32'd0);

      // Both edges in the same cycle are ignored
      ticks(200);
      btn_left  = 1'b1;
      btn_right = 1'b1;
      step();
      chk("both_edges_no_pulse", 32'({jump_left, jump_right}), 32'd0);
      step();
      chk("both_edges_score", 32'(score), 32'd2);
      btn_left  = 1'b0;
      btn_right = 1'b0;
      step();

      // Held level gives exactly one pulse (B387 -> 670F)
      btn_left = 1'b1;
      cnt = 0;
      for (int k = 0; k < 1000; k++) begin
         step();
         if (jump_left) cnt++;
      end
      model_jump();
      chk("hold_one_pulse", 32'(cnt), 32'd1);
      chk("hold_score", 32'(score), 32'd3);
      chk("j3_layer_map", 32'(layer_map_out), 32'(7'b0111011));
      chk("j3_block_type", 32'(block_type_out), 32'(7'b0000011));
      btn_left = 1'b0;

      // Fail during SHIFT
      jump_fail = 1'b1;
      step();
      jump_fail = 1'b0;
      chk("fail_game_over", 32'(game_over), 32'd1);
      chk("fail_module_en", 32'(module_en), 32'd1);
      btn_right = 1'b1;
      step();
      chk("fail_no_pulse", 32'(jump_right), 32'd0);
      btn_right = 1'b0;
      step();
      chk("fail_no_pulse2", 32'(jump_right), 32'd0);
      chk("fail_score_kept", 32'(score), 32'd3);
      chk("fail_row_frozen", 32'(layer_map_out), 32'(7'b0111011));
      btn_start = 1'b1;
      step();
      chk("idle_module_en", 32'(module_en), 32'd0);
      chk("idle_game_over", 32'(game_over), 32'd0);
      chk("idle_layer_map", 32'(layer_map_out), 32'd0);
      chk("idle_block_type", 32'(block_type_out), 32'd0);
      btn_start = 1'b0;
      step();

      // New game, then 1000 fast jumps
      btn_start = 1'b1;
      step();
      chk("new_game_module_en", 32'(module_en), 32'd1);
      chk("new_game_score", 32'(score), 32'd0);
      btn_start = 1'b0;
      m_path = 3;
      prev   = 3;
      force dut.anim_cnt = 10'd1;
      one_ms_tick = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (i[0]) btn_left = 1'b1;
         else      btn_right = 1'b1;
         step();
         model_jump();
         chk("loop_pulse", 32'({jump_left, jump_right}), i[0] ? 32'd2 : 32'd1);
         chk("loop_layer_map", 32'(layer_map_out), 32'(m_map));
         chk("loop_block_type", 32'(block_type_out), 32'(m_type));
         safe = 0;
         for (int p = prev - 1; p <= prev + 1; p++) begin
            if (p >= 0 && p <= 6) begin
               if (layer_map_out[p] && !block_type_out[p]) safe = 1;
            end
         end
         chk("loop_safe_col", 32'(safe), 32'd1);
         prev      = m_path;
         btn_left  = 1'b0;
         btn_right = 1'b0;
         step();
      end
      chk("loop_score", 32'(score), 32'd1000);

      // Score saturation
      force dut.score = 16'hFFFE;
      step();
      release dut.score;
      chk("sat_preload", 32'(score), 32'hFFFE);
      btn_right = 1'b1;
      step();
      chk("sat_first", 32'(score), 32'hFFFF);
      btn_right = 1'b0;
      step();
      btn_right = 1'b1;
      step();
      chk("sat_second", 32'(score), 32'hFFFF);
      chk("sat_pulse", 32'(jump_right), 32'd1);
      btn_right = 1'b0;
      step();
      release dut.anim_cnt;
      one_ms_tick = 1'b0;
      step();

      // Edge mid-SHIFT, no edge after expiry: pulse only with the buffer
      btn_right = 1'b1;
      step();
      chk("buf_jump_issued", 32'(jump_right), 32'd1);
      btn_right = 1'b0;
      step();
      ticks(5);
      btn_left = 1'b1;
      step();
      btn_left = 1'b0;
      step();
      ticks(194);
      one_ms_tick = 1'b1;
      step();
      one_ms_tick = 1'b0;
      step();
      chk("buf_first_ready_pulse", 32'(jump_left), 32'(BUF_EN));

      // Reset in the middle of an animation
      btn_right = 1'b1;
      step();
      btn_right = 1'b0;
      ticks(3);
      rst = 1'b1;
      step();
      chk_reset("mid_shift_rst");
      rst = 1'b0;
      step();
      chk("post_rst_idle", 32'(module_en), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
